// File: rtl/or1200_dc_maint_pkg.sv
// Shared types and constants for the data-cache range maintenance sequencer.
package or1200_dc_maint_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        GAP,
        FIN
    } dc_maint_state_e;

    localparam logic [1:0] CMD_FLUSH  = 2'd1;
    localparam logic [1:0] CMD_WB     = 2'd2;

    localparam logic [1:0] REG_START  = 2'd0;
    localparam logic [1:0] REG_COUNT  = 2'd1;
    localparam logic [1:0] REG_CMD    = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    // Only flush and writeback touch cache lines; other opcodes complete immediately.
    function automatic logic is_line_op(input logic [1:0] op);
        return (op == CMD_FLUSH) || (op == CMD_WB);
    endfunction

endpackage

// File: rtl/or1200_dc_range_maint_if.sv
// Config bus and DC FSM SPR-port signals of the range maintenance sequencer.
interface or1200_dc_range_maint_if;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_dat;
    logic [31:0] cfg_rdat;
    logic        dc_en;
    logic        mtspr_dc_done;
    logic        spr_cswe;
    logic [31:0] spr_dat_o;
    logic        dc_block_flush;
    logic        dc_block_writeback;
    logic        busy;
    logic        done_o;

    modport slave (
        input  cfg_we, cfg_addr, cfg_dat, dc_en, mtspr_dc_done,
        output cfg_rdat, spr_cswe, spr_dat_o, dc_block_flush, dc_block_writeback,
               busy, done_o
    );

    modport master (
        output cfg_we, cfg_addr, cfg_dat, dc_en, mtspr_dc_done,
        input  cfg_rdat, spr_cswe, spr_dat_o, dc_block_flush, dc_block_writeback,
               busy, done_o
    );
endinterface

// File: rtl/or1200_dc_maint_regs.sv
// START/COUNT/CMD/STATUS register file; writes are gated while a sequence runs.
module or1200_dc_maint_regs #(
    parameter int LINE_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_addr,
    input  logic [31:0]       cfg_dat,
    input  logic              busy,
    input  logic              done_pulse,
    input  logic              abort_pulse,
    input  logic              tmo_pulse,
    output logic [31:0]       start,
    output logic [CNT_W-1:0]  count,
    output logic              cmd_go,
    output logic              abort_req,
    output logic [1:0]        cmd_op,
    output logic [31:0]       cfg_rdat
);
    import or1200_dc_maint_pkg::*;

    logic [31-LINE_W:0] start_hi_reg;
    logic [CNT_W-1:0]   count_reg;
    logic [1:0]         cmd_reg;
    logic               done_sticky_reg;
    logic               aborted_reg;
    logic               tmo_err_reg;
    logic               cmd_wr;

    assign cmd_wr    = cfg_we && (cfg_addr == REG_CMD);
    // A CMD write with bit 31 set is an abort: only meaningful while busy, ignored in idle.
    assign cmd_go    = cmd_wr && !busy && !cfg_dat[31];
    assign abort_req = cmd_wr && busy && cfg_dat[31];
    assign cmd_op    = cfg_dat[1:0];
    assign start     = {start_hi_reg, {LINE_W{1'b0}}};
    assign count     = count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_hi_reg    <= '0;
            count_reg       <= '0;
            cmd_reg         <= '0;
            done_sticky_reg <= 1'b0;
            aborted_reg     <= 1'b0;
            tmo_err_reg     <= 1'b0;
        end else begin
            if (cfg_we && !busy && (cfg_addr == REG_START)) begin
                start_hi_reg <= cfg_dat[31:LINE_W];
            end
            if (cfg_we && !busy && (cfg_addr == REG_COUNT)) begin
                count_reg <= cfg_dat[CNT_W-1:0];
            end
            if (cmd_go) begin
                cmd_reg         <= cfg_dat[1:0];
                done_sticky_reg <= 1'b0;
                aborted_reg     <= 1'b0;
                tmo_err_reg     <= 1'b0;
            end else begin
                if (done_pulse)  done_sticky_reg <= 1'b1;
                if (abort_pulse) aborted_reg     <= 1'b1;
                if (tmo_pulse)   tmo_err_reg     <= 1'b1;
            end
        end
    end

    always_comb begin
        cfg_rdat = '0;
        case (cfg_addr)
            REG_START:  cfg_rdat = start;
            REG_COUNT:  cfg_rdat = {{(32-CNT_W){1'b0}}, count_reg};
            REG_CMD:    cfg_rdat = {30'b0, cmd_reg};
            default:    cfg_rdat = {28'b0, tmo_err_reg, aborted_reg, done_sticky_reg, busy};
        endcase
    end

endmodule

// File: rtl/or1200_dc_range_maint.sv
// Walks an address range one cache line at a time, driving the DC FSM SPR port
// with a block flush or writeback per line and a one-cycle release between lines.
module or1200_dc_range_maint #(
    parameter int LINE_W = 4,
    parameter int CNT_W  = 16,
    parameter int TMO_W  = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    or1200_dc_range_maint_if.slave  bus
);
    import or1200_dc_maint_pkg::*;

    localparam logic [31:0] STEP = 32'd1 << LINE_W;

    dc_maint_state_e    state;
    logic [31:0]        addr;
    logic [CNT_W-1:0]   rem;
    logic [TMO_W-1:0]   tmo;
    logic [TMO_W-1:0]   tmo_inc;
    logic [1:0]         op_reg;
    logic               abort_pending_reg;
    logic               cswe_reg;
    logic               flush_reg;
    logic               wb_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               fin_abort_reg;
    logic               fin_tmo_reg;

    logic [31:0]        start;
    logic [CNT_W-1:0]   count;
    logic               cmd_go;
    logic               abort_req;
    logic [1:0]         cmd_op;

    or1200_dc_maint_regs #(
        .LINE_W (LINE_W),
        .CNT_W  (CNT_W)
    ) u_regs (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (bus.cfg_we),
        .cfg_addr    (bus.cfg_addr),
        .cfg_dat     (bus.cfg_dat),
        .busy        (busy_reg),
        .done_pulse  (done_reg),
        .abort_pulse (fin_abort_reg),
        .tmo_pulse   (fin_tmo_reg),
        .start       (start),
        .count       (count),
        .cmd_go      (cmd_go),
        .abort_req   (abort_req),
        .cmd_op      (cmd_op),
        .cfg_rdat    (bus.cfg_rdat)
    );

    // Timeout fires on the WAIT cycle where the counter would reach all-ones.
    assign tmo_inc = tmo + TMO_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            addr              <= '0;
            rem               <= '0;
            tmo               <= '0;
            op_reg            <= '0;
            abort_pending_reg <= 1'b0;
            cswe_reg          <= 1'b0;
            flush_reg         <= 1'b0;
            wb_reg            <= 1'b0;
            busy_reg          <= 1'b0;
            done_reg          <= 1'b0;
            fin_abort_reg     <= 1'b0;
            fin_tmo_reg       <= 1'b0;
        end else begin
            flush_reg     <= 1'b0;
            wb_reg        <= 1'b0;
            done_reg      <= 1'b0;
            fin_abort_reg <= 1'b0;
            fin_tmo_reg   <= 1'b0;
            if (abort_req && (state == ISSUE || state == WAIT)) begin
                abort_pending_reg <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (cmd_go) begin
                        busy_reg <= 1'b1;
                        if (is_line_op(cmd_op) && (count != '0) && bus.dc_en) begin
                            state             <= ISSUE;
                            addr              <= start;
                            rem               <= count;
                            op_reg            <= cmd_op;
                            abort_pending_reg <= 1'b0;
                            cswe_reg          <= 1'b1;
                            flush_reg         <= (cmd_op == CMD_FLUSH);
                            wb_reg            <= (cmd_op == CMD_WB);
                        end else begin
                            state    <= FIN;
                            done_reg <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    tmo   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (bus.mtspr_dc_done) begin
                        state    <= GAP;
                        cswe_reg <= 1'b0;
                        addr     <= addr + STEP;
                        rem      <= rem - CNT_W'(1);
                    end else if (&tmo_inc) begin
                        state       <= FIN;
                        cswe_reg    <= 1'b0;
                        tmo         <= tmo_inc;
                        done_reg    <= 1'b1;
                        fin_tmo_reg <= 1'b1;
                    end else begin
                        tmo <= tmo_inc;
                    end
                end
                GAP: begin
                    if (rem == '0) begin
                        state    <= FIN;
                        done_reg <= 1'b1;
                    end else if (abort_pending_reg || abort_req || !bus.dc_en) begin
                        state         <= FIN;
                        done_reg      <= 1'b1;
                        fin_abort_reg <= 1'b1;
                    end else begin
                        state     <= ISSUE;
                        cswe_reg  <= 1'b1;
                        flush_reg <= (op_reg == CMD_FLUSH);
                        wb_reg    <= (op_reg == CMD_WB);
                    end
                end
                FIN: begin
                    state             <= IDLE;
                    busy_reg          <= 1'b0;
                    abort_pending_reg <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    busy_reg <= 1'b0;
                    cswe_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.spr_cswe           = cswe_reg;
    assign bus.spr_dat_o          = addr;
    assign bus.dc_block_flush     = flush_reg;
    assign bus.dc_block_writeback = wb_reg;
    assign bus.busy               = busy_reg;
    assign bus.done_o             = done_reg;

endmodule

// File: tb/tb_or1200_dc_range_maint.sv
// Randomized and directed bench for the range maintenance sequencer, with a
// line-level reference model and a DC FSM responder with per-line done delays.
module tb_or1200_dc_range_maint;
    localparam int LINE_W  = 4;
    localparam int CNT_W   = 16;
    localparam int TMO_W   = 4;
    localparam int TMO_LIM = (1 << TMO_W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   dly[64];

    or1200_dc_range_maint_if bus();

    or1200_dc_range_maint #(
        .LINE_W (LINE_W),
        .CNT_W  (CNT_W),
        .TMO_W  (TMO_W)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = a;
        bus.cfg_dat  = d;
        @(negedge clk);
        bus.cfg_we   = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
        bus.cfg_addr = a;
        #1;
        d = bus.cfg_rdat;
    endtask

    task automatic set_dly(input int v);
        for (int i = 0; i < 64; i++) dly[i] = v;
    endtask

    // abort_line: 1-based line during whose first WAIT cycle an abort is written; 0 = none.
    task automatic run_seq(input logic [31:0] start, input int count, input logic [1:0] op,
                           input logic en, input int abort_line);
        logic [31:0] got_addr[64];
        logic        got_fl[64];
        int          got_cs[64];
        int          n_got, n_done, done_idx, gap_err, j, cs_len;
        int          n_exp, exp_idx, lim;
        bit          tmo_hit, ab, finished;
        logic        prev_cswe;
        logic [31:0] rd, exp_status, base;

        // Reference: every line costs ISSUE + d WAIT + GAP unless it times out.
        n_exp = 0; exp_idx = 0; tmo_hit = 0; ab = 0;
        if ((op == 2'd1 || op == 2'd2) && count != 0 && en) begin
            for (int i = 0; i < count; i++) begin
                n_exp++;
                if (dly[i] > TMO_LIM) begin
                    exp_idx += 1 + TMO_LIM;
                    tmo_hit = 1;
                    break;
                end
                exp_idx += 2 + dly[i];
                if (i == count - 1) break;
                if (abort_line == i + 1) begin
                    ab = 1;
                    break;
                end
            end
        end
        exp_status = 32'h2 | (ab ? 32'h4 : 32'h0) | (tmo_hit ? 32'h8 : 32'h0);
        base = start & 32'hFFFF_FFF0;

        cfg_write(2'd0, start);
        cfg_write(2'd1, 32'(count));
        bus.dc_en    = en;
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 2'd2;
        bus.cfg_dat  = {30'b0, op};

        n_got = 0; n_done = 0; done_idx = -1; gap_err = 0; j = 0; cs_len = 0;
        prev_cswe = 1'b0; finished = 0;
        for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
            @(negedge clk);
            bus.cfg_we = 1'b0;
            if (cyc == 0) begin
                check_val("busy_start", 32'(bus.busy), 32'd1);
                bus.cfg_we   = 1'b1;
                bus.cfg_addr = 2'd0;
                bus.cfg_dat  = $urandom;
            end
            if (bus.dc_block_flush || bus.dc_block_writeback) begin
                if (prev_cswe) gap_err++;
                if (n_got < 64) begin
                    got_addr[n_got] = bus.spr_dat_o;
                    got_fl[n_got]   = bus.dc_block_flush;
                end
                n_got++;
                j = 0;
                cs_len = 1;
                bus.mtspr_dc_done = 1'($urandom_range(0, 1));
            end else if (bus.spr_cswe) begin
                j++;
                cs_len++;
                bus.mtspr_dc_done = (n_got > 0 && n_got <= 64) ? (j == dly[n_got-1]) : 1'b0;
                if (n_got == abort_line && j == 1) begin
                    bus.cfg_we   = 1'b1;
                    bus.cfg_addr = 2'd2;
                    bus.cfg_dat  = 32'h8000_0000;
                end
            end else begin
                if (prev_cswe && n_got > 0 && n_got <= 64) got_cs[n_got-1] = cs_len;
                bus.mtspr_dc_done = 1'b0;
            end
            if (bus.done_o) begin
                n_done++;
                done_idx = cyc;
                finished = 1;
                bus.cfg_we   = 1'b1;
                bus.cfg_addr = 2'd2;
                bus.cfg_dat  = 32'h1;
            end
            prev_cswe = bus.spr_cswe;
        end
        if (!finished) check_val("done_seen", 32'd0, 32'd1);

        @(negedge clk);
        bus.cfg_we = 1'b0;
        bus.mtspr_dc_done = 1'b0;
        check_val("busy_end", 32'(bus.busy), 32'd0);
        check_val("done_single", 32'(bus.done_o), 32'd0);
        read_reg(2'd3, rd);
        check_val("status", rd, exp_status);
        read_reg(2'd0, rd);
        check_val("start_rd", rd, base);
        read_reg(2'd1, rd);
        check_val("count_rd", rd, 32'(count) & 32'h0000_FFFF);

        check_val("lines", 32'(n_got), 32'(n_exp));
        check_val("gap", 32'(gap_err), 32'd0);
        if (finished) check_val("done_lat", 32'(done_idx), 32'(exp_idx));
        lim = (n_got < n_exp) ? n_got : n_exp;
        for (int i = 0; i < lim && i < 64; i++) begin
            check_val("line_addr", got_addr[i], base + 32'(i) * 32'd16);
            check_val("line_op", 32'(got_fl[i]), (op == 2'd1) ? 32'd1 : 32'd0);
            check_val("cswe_len", 32'(got_cs[i]), 32'(1 + ((dly[i] > TMO_LIM) ? TMO_LIM : dly[i])));
        end
        $display("seq start=%h count=%0d op=%0d en=%0d abort=%0d lines=%0d/%0d done_at=%0d status_exp=%h",
                 start, count, op, en, abort_line, n_got, n_exp, done_idx, exp_status);
    endtask

    task automatic reset_mid_seq();
        bit          in_wait;
        logic [31:0] rd;
        set_dly(6);
        cfg_write(2'd0, 32'h2000);
        cfg_write(2'd1, 32'd4);
        bus.dc_en    = 1'b1;
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 2'd2;
        bus.cfg_dat  = 32'h1;
        in_wait = 0;
        for (int cyc = 0; cyc < 50 && !in_wait; cyc++) begin
            @(negedge clk);
            bus.cfg_we = 1'b0;
            if (bus.spr_cswe && !bus.dc_block_flush && !bus.dc_block_writeback) in_wait = 1;
        end
        check_val("reach_wait", 32'(in_wait), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("rst_cswe", 32'(bus.spr_cswe), 32'd0);
        check_val("rst_busy", 32'(bus.busy), 32'd0);
        check_val("rst_done", 32'(bus.done_o), 32'd0);
        check_val("rst_dat", bus.spr_dat_o, 32'd0);
        read_reg(2'd3, rd);
        check_val("rst_status", rd, 32'd0);
        $display("reset asserted mid-sequence");
        @(negedge clk);
        rst_n = 1'b1;
        run_seq(32'h3000, 0, 2'd1, 1'b1, 0);
    endtask

    initial begin
        logic [31:0] rd;
        int          cnt, ab_line;
        logic [1:0]  op;
        bus.cfg_we = 1'b0;
        bus.cfg_addr = 2'd0;
        bus.cfg_dat = '0;
        bus.dc_en = 1'b1;
        bus.mtspr_dc_done = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_cswe", 32'(bus.spr_cswe), 32'd0);
        check_val("reset_busy", 32'(bus.busy), 32'd0);
        check_val("reset_done", 32'(bus.done_o), 32'd0);
        check_val("reset_dat", bus.spr_dat_o, 32'd0);
        read_reg(2'd3, rd);
        check_val("reset_status", rd, 32'd0);
        $display("reset checked");
        rst_n = 1'b1;

        set_dly(2); run_seq(32'h0000_1007, 3, 2'd1, 1'b1, 0);
        set_dly(1); run_seq(32'h0000_0040, 1, 2'd2, 1'b1, 0);
        set_dly(1); run_seq(32'hFFFF_FFF0, 2, 2'd1, 1'b1, 0);
        set_dly(3); run_seq(32'h0000_8000, 8, 2'd1, 1'b1, 2);
        set_dly(100); run_seq(32'h0000_0500, 3, 2'd1, 1'b1, 0);
        set_dly(2); run_seq(32'h0000_0100, 2, 2'd3, 1'b1, 0);
        set_dly(2); run_seq(32'h0000_0100, 2, 2'd1, 1'b0, 0);
        set_dly(2); run_seq(32'h0000_0200, 3, 2'd2, 1'b1, 3);
        reset_mid_seq();

        for (int t = 0; t < 25; t++) begin
            cnt = $urandom_range(0, 6);
            op  = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'($urandom_range(1, 2));
            for (int i = 0; i < 64; i++) begin
                dly[i] = ($urandom_range(0, 19) == 0) ? 16 + $urandom_range(0, 4) : $urandom_range(1, 5);
            end
            ab_line = ($urandom_range(0, 2) == 0) ? $urandom_range(1, (cnt > 0) ? cnt : 1) : 0;
            run_seq($urandom, cnt, op, ($urandom_range(0, 9) != 0), ab_line);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
